// File: rtl/ram_pkg.sv
// Shared encodings for the RAM access unit: FSM states, access sizes and read/write codes.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [1:0] TYPE_BYTE = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Lane i addresses byte A+i; lane 0 is the most significant byte (big-endian).
    function automatic logic [3:0] lane_mask(input logic [1:0] typ);
        case (typ)
            TYPE_BYTE: lane_mask = 4'b0001;
            TYPE_HALF: lane_mask = 4'b0011;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// DEPTH x 8 storage with four byte lanes at A..A+3 (mod DEPTH).
// Synchronous write, combinational read; lane 0 sits on bits [31:24].
module ram_byte_array #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr + AW'(i)] <= wdata[31-8*i -: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < 4; i++) begin
            rdata[31-8*i -: 8] = mem[addr + AW'(i)];
        end
    end

endmodule

// File: rtl/ram_access_unit.sv
// Byte-addressed big-endian memory serving MFA/MOC requests with WAIT_CYCLES latency.
// Optional macro ALIGN_CHECK_EN: report misaligned accesses via Fault instead of force-aligning.
module ram_access_unit
    import ram_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  Type,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Fault
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: request latched when MFA is sampled high in IDLE; MOC stays high in ACK
    // until MFA is sampled low, so every new request needs one low MFA sample first.
    state_t        state, state_next;
    logic [3:0]    cnt;
    logic [AW-1:0] req_addr;
    logic          req_rw;
    logic [1:0]    req_type;
    logic [31:0]   req_data;

    logic          access, fault_hit, is_word, is_half, moc_d;
    logic [AW-1:0] acc_addr;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata, lane_rdata, rd_value;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^Address[31:AW];

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MFA) state_next = WAIT;
            WAIT:    if (cnt == 4'd0) state_next = ACK;
            ACK:     if (!MFA) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        is_word  = req_type[1];
        is_half  = (req_type == TYPE_HALF);
        acc_addr = req_addr & ~(is_word ? AW'(3) : (is_half ? AW'(1) : AW'(0)));
`ifdef ALIGN_CHECK_EN
        fault_hit = is_word ? (|req_addr[1:0]) : (is_half & req_addr[0]);
`else
        fault_hit = 1'b0;
`endif
        access  = (state == WAIT) && (cnt == 4'd0);
        lane_we = (access && req_rw == RW_WRITE && !fault_hit) ? lane_mask(req_type) : 4'b0000;
        moc_d   = (state_next == ACK);
        case (req_type)
            TYPE_BYTE: begin
                lane_wdata = {req_data[7:0], 24'h0};
                rd_value   = {24'h0, lane_rdata[31:24]};
            end
            TYPE_HALF: begin
                lane_wdata = {req_data[15:0], 16'h0};
                rd_value   = {16'h0, lane_rdata[31:16]};
            end
            default: begin
                lane_wdata = req_data;
                rd_value   = lane_rdata;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt      <= 4'd0;
            req_addr <= '0;
            req_rw   <= RW_READ;
            req_type <= TYPE_BYTE;
            req_data <= 32'h0;
            MOC      <= 1'b0;
            DataOut  <= 32'h0;
        end else begin
            MOC <= moc_d;
            if (state == IDLE && MFA) begin
                req_addr <= Address[AW-1:0];
                req_rw   <= RW;
                req_type <= Type;
                req_data <= DataIn;
                cnt      <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                if (fault_hit)             DataOut <= 32'h0;
                else if (req_rw == RW_READ) DataOut <= rd_value;
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr)                        Fault <= 1'b0;
        else if (access)                 Fault <= fault_hit;
        else if (state == ACK && !MFA)   Fault <= 1'b0;
    end
`else
    assign Fault = 1'b0;
`endif

    ram_byte_array #(.DEPTH(DEPTH)) u_array (
        .Clk   (Clk),
        .addr  (acc_addr),
        .we    (lane_we),
        .wdata (lane_wdata),
        .rdata (lane_rdata)
    );

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_ram_access_unit;
    import ram_pkg::*;

    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    logic        mfa_a, rw_a, moc_a, fault_a;
    logic [1:0]  type_a;
    logic [31:0] addr_a, din_a, dout_a;
    logic        mfa_b, rw_b, moc_b, fault_b;
    logic [1:0]  type_b;
    logic [31:0] addr_b, din_b, dout_b;

    int n_assert = 0;
    int n_fail   = 0;

    ram_access_unit #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Clr(Clr), .MFA(mfa_a), .RW(rw_a), .Type(type_a), .Address(addr_a),
        .DataIn(din_a), .DataOut(dout_a), .MOC(moc_a), .Fault(fault_a)
    );

    ram_access_unit #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_z (
        .Clk(Clk), .Clr(Clr), .MFA(mfa_b), .RW(rw_b), .Type(type_b), .Address(addr_b),
        .DataIn(din_b), .DataOut(dout_b), .MOC(moc_b), .Fault(fault_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One complete request: raise MFA, wait (bounded) for MOC, optionally hold, then release.
    task automatic mem_op(input bit sel, input logic rw, input logic [1:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int hold, input int exp_lat, input string tag,
                          output logic [31:0] rd, output logic flt);
        int  iters;
        bit  done;
        if (!sel) begin
            mfa_a = 1'b1; rw_a = rw; type_a = typ; addr_a = addr; din_a = data;
        end else begin
            mfa_b = 1'b1; rw_b = rw; type_b = typ; addr_b = addr; din_b = data;
        end
        iters = 0;
        done  = 1'b0;
        while (!done && iters < 40) begin
            step();
            iters++;
            done = sel ? moc_b : moc_a;
        end
        check({tag, " latency"}, 32'(iters - 1), 32'(exp_lat));
        rd  = sel ? dout_b : dout_a;
        flt = sel ? fault_b : fault_a;
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, " moc_hold"}, {31'h0, sel ? moc_b : moc_a}, 32'h1);
        end
        if (!sel) mfa_a = 1'b0;
        else      mfa_b = 1'b0;
        step();
        check({tag, " moc_drop"}, {31'h0, sel ? moc_b : moc_a}, 32'h0);
        check({tag, " fault_clear"}, {31'h0, sel ? fault_b : fault_a}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        flt;

        Clr = 1'b0;
        mfa_a = 1'b0; rw_a = RW_READ; type_a = TYPE_BYTE; addr_a = '0; din_a = '0;
        mfa_b = 1'b0; rw_b = RW_READ; type_b = TYPE_BYTE; addr_b = '0; din_b = '0;
        step(); step();
        check("reset moc", {31'h0, moc_a}, 32'h0);
        check("reset dataout", dout_a, 32'h0);
        check("reset fault", {31'h0, fault_a}, 32'h0);
        Clr = 1'b1;
        step();

        mem_op(0, RW_WRITE, TYPE_WORD, 32'h10, 32'hDEADBEEF, 0, 3, "wr_word10", rd, flt);
        mem_op(0, RW_READ, TYPE_WORD, 32'h10, 32'h0, 0, 3, "rd_word10", rd, flt);
        check("rd_word10 data", rd, 32'hDEADBEEF);
        check("rd_word10 fault", {31'h0, flt}, 32'h0);
        mem_op(0, RW_READ, TYPE_BYTE, 32'h10, 32'h0, 0, 3, "rd_byte10", rd, flt);
        check("rd_byte10 data", rd, 32'h000000DE);

        mem_op(0, RW_WRITE, TYPE_BYTE, 32'h13, 32'hFFFFFF5A, 0, 3, "wr_byte13", rd, flt);
        check("write keeps dataout", dout_a, 32'h000000DE);
        mem_op(0, RW_READ, TYPE_WORD, 32'h10, 32'h0, 0, 3, "rd_word10b", rd, flt);
        check("rd_word10b data", rd, 32'hDEADBE5A);
        mem_op(0, RW_READ, TYPE_HALF, 32'h12, 32'h0, 0, 3, "rd_half12", rd, flt);
        check("rd_half12 data", rd, 32'h0000BE5A);
        mem_op(0, RW_READ, TYPE_BYTE, 32'h11, 32'h0, 0, 3, "rd_byte11", rd, flt);
        check("rd_byte11 data", rd, 32'h000000AD);

        mem_op(0, RW_WRITE, TYPE_WORD, 32'h30, 32'h0BADCAFE, 5, 3, "hold_wr30", rd, flt);
        step();
        check("idle moc stays low", {31'h0, moc_a}, 32'h0);
        mem_op(0, RW_READ, TYPE_WORD, 32'h30, 32'h0, 0, 3, "rd_word30", rd, flt);
        check("rd_word30 data", rd, 32'h0BADCAFE);

        mem_op(0, RW_WRITE, TYPE_WORD, 32'h20, 32'h11223344, 0, 3, "wr_word20", rd, flt);
        mem_op(0, RW_READ, TYPE_WORD, 32'h20, 32'h0, 0, 3, "rd_word20", rd, flt);
        check("rd_word20 data", rd, 32'h11223344);
        mfa_a = 1'b1; rw_a = RW_WRITE; type_a = TYPE_WORD; addr_a = 32'h20; din_a = 32'hAAAAAAAA;
        step();
        step();
        check("midwait moc low", {31'h0, moc_a}, 32'h0);
        Clr = 1'b0;
        #1;
        check("midwait reset moc", {31'h0, moc_a}, 32'h0);
        check("midwait reset dataout", dout_a, 32'h0);
        check("midwait reset fault", {31'h0, fault_a}, 32'h0);
        mfa_a = 1'b0;
        step();
        Clr = 1'b1;
        step();
        mem_op(0, RW_READ, TYPE_WORD, 32'h20, 32'h0, 0, 3, "rd_word20_after", rd, flt);
        check("dropped write data", rd, 32'h11223344);

`ifdef ALIGN_CHECK_EN
        mem_op(0, RW_READ, TYPE_WORD, 32'h11, 32'h0, 0, 3, "mis_rd11", rd, flt);
        check("mis_rd11 data", rd, 32'h0);
        check("mis_rd11 fault", {31'h0, flt}, 32'h1);
        mem_op(0, RW_WRITE, TYPE_WORD, 32'h12, 32'hCAFEF00D, 0, 3, "mis_wr12", rd, flt);
        check("mis_wr12 fault", {31'h0, flt}, 32'h1);
        check("mis_wr12 dataout", rd, 32'h0);
        mem_op(0, RW_READ, TYPE_WORD, 32'h10, 32'h0, 0, 3, "after_mis_rd10", rd, flt);
        check("after_mis_rd10 data", rd, 32'hDEADBE5A);
        mem_op(0, RW_READ, TYPE_HALF, 32'h13, 32'h0, 0, 3, "mis_half13", rd, flt);
        check("mis_half13 fault", {31'h0, flt}, 32'h1);
        check("mis_half13 data", rd, 32'h0);
`else
        mem_op(0, RW_READ, TYPE_WORD, 32'h11, 32'h0, 0, 3, "mis_rd11", rd, flt);
        check("mis_rd11 data", rd, 32'hDEADBE5A);
        check("mis_rd11 fault", {31'h0, flt}, 32'h0);
        mem_op(0, RW_WRITE, TYPE_HALF, 32'h13, 32'h00001234, 0, 3, "mis_half_wr13", rd, flt);
        check("mis_half_wr13 fault", {31'h0, flt}, 32'h0);
        mem_op(0, RW_READ, TYPE_WORD, 32'h10, 32'h0, 0, 3, "after_mis_rd10", rd, flt);
        check("after_mis_rd10 data", rd, 32'hDEAD1234);
`endif

        mem_op(1, RW_WRITE, TYPE_WORD, 32'hFC, 32'h01020304, 0, 1, "z_wr_fc", rd, flt);
        mem_op(1, RW_READ, TYPE_WORD, 32'hFC, 32'h0, 0, 1, "z_rd_fc", rd, flt);
        check("z_rd_fc data", rd, 32'h01020304);
        mem_op(1, RW_READ, TYPE_WORD, 32'h100000FC, 32'h0, 0, 1, "z_rd_hi", rd, flt);
        check("z_rd_hi data", rd, 32'h01020304);
        mem_op(1, RW_READ, TYPE_BYTE, 32'hFF, 32'h0, 0, 1, "z_rd_ff", rd, flt);
        check("z_rd_ff data", rd, 32'h00000004);
        mem_op(1, RW_READ, TYPE_HALF, 32'hFE, 32'h0, 0, 1, "z_rd_fe", rd, flt);
        check("z_rd_fe data", rd, 32'h00000304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
